// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and port indices for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAR,
        ST_WMDR,
        ST_WRAM,
        ST_RRAM,
        ST_RMDR,
        ST_ACK
    } state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin pick; a tie goes to the port not granted last
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (last == 1'(PORT_DMA)) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port arbiter sequencing MAR/MDR/RAM strobes onto a shared bus
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              hold,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              set_mar,
    output logic              write_m,
    output logic              read_m,
    output logic              write_r,
    output logic              read_r,
    output logic [ADDR_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [ADDR_W-1:0] bus_in
);

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, ack_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                busy_q, bus_oe_q;
    logic                set_mar_q, write_m_q, read_m_q, write_r_q, read_r_q;
    logic                owner_q, dir_q, last_q;
    logic [1:0]          rr_grant;
    logic                rr_port;
    logic                start;
    logic                unused_bus_hi;

    assign unused_bus_hi = ^bus_in[ADDR_W-1:DATA_W];

    mem_arb_rr u_rr (
        .req   (req),
        .last  (last_q),
        .grant (rr_grant)
    );

    assign rr_port = rr_grant[PORT_DMA];
    assign start   = (state_q == ST_IDLE) && !hold && (req != 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_MAR;
            ST_MAR:  state_d = dir_q ? ST_WMDR : ST_RRAM;
            ST_WMDR: state_d = ST_WRAM;
            ST_WRAM: state_d = ST_ACK;
            ST_RRAM: state_d = ST_RMDR;
            ST_RMDR: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with state_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            ack_q     <= 2'b00;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            bus_oe_q  <= 1'b0;
            set_mar_q <= 1'b0;
            write_m_q <= 1'b0;
            read_m_q  <= 1'b0;
            write_r_q <= 1'b0;
            read_r_q  <= 1'b0;
            owner_q   <= 1'b0;
            dir_q     <= 1'b0;
            last_q    <= 1'(PORT_DMA);
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != ST_IDLE);
            bus_oe_q  <= (state_d == ST_MAR) || (state_d == ST_WMDR);
            set_mar_q <= (state_d == ST_MAR);
            write_m_q <= (state_d == ST_WMDR);
            write_r_q <= (state_d == ST_WRAM);
            read_r_q  <= (state_d == ST_RRAM);
            read_m_q  <= (state_d == ST_RMDR);
            ack_q     <= (state_d == ST_ACK) ? port_onehot(owner_q) : 2'b00;
            if (start) begin
                gnt_q   <= rr_grant;
                owner_q <= rr_port;
                last_q  <= rr_port;
                dir_q   <= we[rr_port];
            end else if (state_d == ST_ACK) begin
                gnt_q   <= 2'b00;
            end
            if (state_q == ST_RMDR) begin
                rdata_q <= bus_in[DATA_W-1:0];
            end
        end
    end

    // Address and write data are taken live from the owning port
    always_comb begin
        bus_out = '0;
        case (state_q)
            ST_MAR:  bus_out = owner_q ? addr1 : addr0;
            ST_WMDR: bus_out = ADDR_W'(owner_q ? wdata1 : wdata0);
            default: bus_out = '0;
        endcase
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign bus_oe  = bus_oe_q;
    assign set_mar = set_mar_q;
    assign write_m = write_m_q;
    assign read_m  = read_m_q;
    assign write_r = write_r_q;
    assign read_r  = read_r_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, sets the requester address width and the bus width.
REQ-002 Parameter DATA_W, default 8, sets the requester data width; the low DATA_W bits of the bus carry data.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req  in  2  per-port access request, bit 0 = CPU port, bit 1 = loader/DMA port.
REQ-006 we  in  2  per-port direction: 1 = write, 0 = read.
REQ-007 addr0, addr1  in  ADDR_W each  per-port address.
REQ-008 wdata0, wdata1  in  DATA_W each  per-port write data.
REQ-009 hold  in  1  blocks new grants; an in-flight transaction completes.
REQ-010 gnt  out  2  one-hot, registered; the granted port, held for the whole transaction.
REQ-011 ack  out  2  one-cycle completion pulse to the granted port.
REQ-012 rdata  out  DATA_W  registered read data, valid in the ack cycle and held until the next read completes.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 set_mar, write_m, read_m, write_r, read_r  out  1 each  memory-controller sequencing strobes.
REQ-015 bus_out  out  ADDR_W  value driven toward the shared data bus.
REQ-016 bus_oe  out  1  bus_out valid/drive enable.
REQ-017 bus_in  in  ADDR_W  shared data bus as seen by the arbiter.

Function
REQ-018 States shall be IDLE, MAR, WMDR, WRAM, RRAM, RMDR, ACK.
REQ-019 In IDLE with hold=0 and any req bit set, the arbiter shall register the winner into gnt and move to MAR on the next edge.
REQ-020 Arbitration shall be round-robin: with both req bits set, the port not granted last wins; with one bit set, that port wins.
REQ-021 The last-granted register shall update on every grant; its reset value shall be port 1, so port 0 wins the first tie.
REQ-022 MAR: set_mar=1, bus_oe=1, bus_out=addr of the granted port; next state WMDR if the latched we=1, else RRAM.
REQ-023 WMDR: write_m=1, bus_oe=1, bus_out = zero-extended wdata; next state WRAM.
REQ-024 WRAM: write_r=1; next state ACK.
REQ-025 RRAM: read_r=1; next state RMDR.
REQ-026 RMDR: read_m=1; rdata shall capture bus_in[DATA_W-1:0] at the end of the cycle; next state ACK.
REQ-027 ACK: ack[granted]=1 for exactly one cycle; gnt shall clear; next state IDLE.
REQ-028 Latency from the grant edge to the ack cycle shall be 4 cycles; back-to-back throughput shall be one transaction per 5 cycles.
REQ-029 Direction shall be latched at grant; addr and wdata are sampled live, and the requester shall hold them stable until ack.
REQ-030 If req drops mid-transaction, the sequence shall still complete and ack shall still pulse.
REQ-031 hold rising mid-transaction shall not abort it; IDLE shall be kept while hold=1.
REQ-032 All strobes and bus_oe shall be 0 in IDLE and ACK, and at most one strobe shall be high in any cycle.

Reset
REQ-033 Asserting reset in any state shall force IDLE immediately.
REQ-034 Under reset, gnt, ack, strobes, bus_oe and busy shall be 0, bus_out and rdata shall be 0, and last-granted shall be port 1.
REQ-035 A transaction interrupted by reset shall produce no ack.

Structure
REQ-036 Package mem_arb_pkg shall hold the state enum and the port index constants PORT_CPU=0 and PORT_DMA=1.
REQ-037 One sub-module, mem_arb_rr, shall implement the two-way round-robin pick: inputs req and last, output one-hot grant.

Verification
REQ-038 Port 0 writes 0xA5 to address 0x0123: MAR(bus_out=0x0123), WMDR(bus_out=0x00A5), WRAM, then ack[0] on the 4th cycle after grant.
REQ-039 Port 1 reads with bus_in=0x003C during RMDR: rdata=0x3C in the ack[1] cycle and held afterward.
REQ-040 Both ports request continuously after reset: grants alternate 0,1,0,1 with a 5-cycle period.
REQ-041 hold=1 raised during WMDR: the transaction completes with ack; no new gnt until hold=0.
REQ-042 reset asserted during RRAM: outputs go to 0 immediately, no ack, and the first post-reset tie grants port 0.
REQ-043 req[0] dropped during WRAM: ack[0] still pulses and the arbiter returns to IDLE.
